// File: rtl/multi_rate_divider.sv
// Multi-channel clock-enable generator: per-channel programmable period producing a
// one-cycle tick and a square wave, plus a legacy 32-bit free-running counter.
module multi_rate_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 24999999,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [31:0]       free_cnt
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) free_cnt <= '0;
    else        free_cnt <= free_cnt + 32'd1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_shadow;
    logic             pending;
    logic             tick_q;
    logic             sq_q;
    logic             we;
    logic             tc;

    // An out-of-range cfg_ch matches no channel, so the write is dropped.
    assign we = cfg_we && (32'(cfg_ch) == 32'(i));
    assign tc = (count >= div_active);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        count      <= '0;
        div_active <= DIV_RST;
        div_shadow <= DIV_RST;
        pending    <= 1'b0;
        tick_q     <= 1'b0;
        sq_q       <= 1'b0;
      end else if (clr) begin
        count  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        if (we) begin
          div_active <= cfg_div;
          div_shadow <= cfg_div;
          pending    <= 1'b0;
        end else if (pending) begin
          div_active <= div_shadow;
          pending    <= 1'b0;
        end
      end else if (en[i]) begin
        if (tc) begin
          count  <= '0;
          tick_q <= 1'b1;
          sq_q   <= ~sq_q;
          if (we) begin
            div_active <= cfg_div;
            div_shadow <= cfg_div;
            pending    <= 1'b0;
          end else if (pending) begin
            div_active <= div_shadow;
            pending    <= 1'b0;
          end
        end else begin
          count  <= count + 1'b1;
          tick_q <= 1'b0;
          if (we) begin
            div_shadow <= cfg_div;
            pending    <= 1'b1;
          end
        end
      end else begin
        tick_q <= 1'b0;
        // A stopped channel takes a new period immediately and restarts from zero.
        if (we) begin
          div_active <= cfg_div;
          div_shadow <= cfg_div;
          count      <= '0;
          pending    <= 1'b0;
        end
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed bench for multi_rate_divider: hand-computed tick/sq timing for period,
// reprogramming, enable gating, clear realignment, async reset and invalid channel writes.
module tb_multi_rate_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en;
  logic        clr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [25:0] cfg_div;
  logic [3:0]  tick;
  logic [3:0]  sq;
  logic [31:0] free_cnt;

  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [2:0]  tick3;
  logic [2:0]  sq3;
  logic [31:0] free3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_rate_divider #(.NUM_CH(4), .CNT_W(26), .DEFAULT_DIV(3)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .tick(tick), .sq(sq), .free_cnt(free_cnt)
  );

  // Three channels leave cfg_ch=3 as an unused code to exercise write rejection.
  multi_rate_divider #(.NUM_CH(3), .CNT_W(26), .DEFAULT_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .en(en[2:0]), .clr(clr), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
    .cfg_div(cfg_div), .tick(tick3), .sq(sq3), .free_cnt(free3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = '0; clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_we3 = 1'b0; cfg_ch3 = '0;
    #3;
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_sq", 32'(sq), 32'h0);
    chk("rst_free", free_cnt, 32'h0);
    chk("rst_tick3", 32'(tick3), 32'h0);
    #9;
    reset = 1'b1;
    en    = 4'hF;

    // Period 4: ticks after edges 4, 8, 12; dut3 ignores writes to channel 3
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("t1_tick", 32'(tick), (k % 4 == 0) ? 32'hF : 32'h0);
      chk("t1_sq", 32'(sq), ((k / 4) % 2 == 1) ? 32'hF : 32'h0);
      chk("inv_tick3", 32'(tick3), (k % 4 == 0) ? 32'h7 : 32'h0);
      cfg_we3 = (k == 1 || k == 2);
      cfg_ch3 = 2'd3;
      cfg_div = '0;
    end
    cfg_we3 = 1'b0;
    chk("t1_free", free_cnt, 32'd12);

    // ch0 div=0 written while disabled, then enabled: tick every cycle
    en = 4'b1110; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 26'd0;
    cyc();
    cfg_we = 1'b0; en = 4'hF;
    chk("t2_dis_tick0", 32'(tick[0]), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("t2_tick0", 32'(tick[0]), 32'h1);
      chk("t2_sq0", 32'(sq[0]), (k % 2 == 0) ? 32'h1 : 32'h0);
    end

    // ch1 div=9, rewrite at count 2 (6 then 4, last wins), then write on terminal count
    en = 4'h0; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 26'd9;
    cyc();
    cfg_ch = 2'd2; cfg_div = 26'd7;
    cyc();
    cfg_we = 1'b0; en = 4'b0010;
    for (int k = 1; k <= 41; k++) begin
      cyc();
      chk("t3_tick1", 32'(tick[1]),
          (k == 10 || k == 20 || k == 25 || k == 30 || k == 35 || k == 38 || k == 41) ? 32'h1 : 32'h0);
      cfg_we  = (k == 12 || k == 13 || k == 34);
      cfg_ch  = 2'd1;
      cfg_div = (k == 12) ? 26'd6 : (k == 13) ? 26'd4 : 26'd2;
    end
    cfg_we = 1'b0;

    // ch2 div=7, disabled for 20 edges with count held at 3
    en = 4'b0100;
    for (int k = 1; k <= 36; k++) begin
      cyc();
      chk("t4_tick2", 32'(tick[2]), (k == 8 || k == 36) ? 32'h1 : 32'h0);
      en = (k >= 11 && k < 31) ? 4'b0000 : 4'b0100;
    end

    // Misalign, queue ch3 div=2 (pending), clear: ch1 and ch3 (both div 2) tick together
    en = 4'hF;
    cyc(); cyc(); cyc();
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 26'd2;
    cyc();
    cfg_we = 1'b0; clr = 1'b1; en = 4'b1010;
    cyc();
    clr = 1'b0;
    chk("t5_clr_tick", 32'(tick), 32'h0);
    chk("t5_clr_sq", 32'(sq), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("t5_tick", 32'(tick), (k % 3 == 0) ? 32'hA : 32'h0);
      chk("t5_sq", 32'(sq), ((k / 3) % 2 == 1) ? 32'hA : 32'h0);
    end

    // Async reset mid-count: outputs clear without a clock edge
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_tick", 32'(tick), 32'h0);
    chk("t6_rst_sq", 32'(sq), 32'h0);
    chk("t6_rst_free", free_cnt, 32'h0);
    chk("t6_rst_free3", free3, 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) cyc();
    chk("t6_free", free_cnt, 32'd5);
    chk("t6_free3", free3, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
